// File: rtl/hworld_seq_adder_top_if.sv
// rtl/hworld_seq_adder_top_if.sv - OBI-style register bus between a host and the seq adder
//
// Purpose: bundles the OBI request (req, addr, we, be, wdata) and response
//          (gnt, rvalid, rdata) signals of the adder's register port.
// Modports:
//   master - drives req/addr/we/be/wdata, receives gnt/rvalid/rdata
//   slave  - receives req/addr/we/be/wdata, drives gnt/rvalid/rdata
interface hworld_seq_adder_top_if;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/hworld_seq_adder_top.sv
// rtl/hworld_seq_adder_top.sv - WIDTH-bit multi-cycle add/subtract engine with OBI register slave
//
// Purpose: operands A/B are written as 32-bit words; a START command ripples CHUNK
//          bits per cycle through a chunk adder, carrying between cycles. Status,
//          result words and carry-out are read back over the same bus.
// Ports:
//   clk_i    - clock
//   rst_i    - asynchronous reset, active-high
//   reg_bus  - OBI register bus (slave modport)
//   irq_o    - done interrupt, DONE & IE (only when HWORLD_SEQ_ADDER_IRQ_EN is defined)
// Optional feature macro: HWORLD_SEQ_ADDER_IRQ_EN (irq_o port and stored CTRL.IE bit).
// Register map (byte offsets, addr[9:0]): 0x00 CTRL, 0x04 STATUS, 0x40 A[i], 0x80 B[i], 0xC0 SUM[i].
module hworld_seq_adder_top #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    hworld_seq_adder_top_if.slave reg_bus
`ifdef HWORLD_SEQ_ADDER_IRQ_EN
    ,
    output logic                  irq_o
`endif
);
    localparam int NW  = WIDTH / 32;
    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [KW-1:0]    K_LAST = KW'(NCH - 1);
    localparam logic [WIDTH-1:0] CMASK  = WIDTH'({CHUNK{1'b1}});

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             rvalid_q;
    logic [31:0]      rdata_q, rdata_d;
    logic             ie_rd;

    // ---------------- address decode ----------------
    logic [9:0] addr;
    logic [1:0] region;
    logic [3:0] idx;
    logic       aligned, idx_ok;
    logic       is_ctrl, is_status, is_a, is_b, is_sum;
    logic       wr_en, rd_en, run;
    logic [8:0] word_sh;

    // Only addr[9:0] is decoded; the rest of the word address is ignored on purpose.
    logic unused_addr_bits;
    assign unused_addr_bits = ^reg_bus.addr[31:10];

    assign addr      = reg_bus.addr[9:0];
    assign region    = addr[7:6];
    assign idx       = addr[5:2];
    assign aligned   = (addr[1:0] == 2'b00) && (addr[9:8] == 2'b00);
    assign idx_ok    = ({1'b0, idx} < 5'(NW));
    assign is_ctrl   = aligned && (region == 2'd0) && (idx == 4'd0);
    assign is_status = aligned && (region == 2'd0) && (idx == 4'd1);
    assign is_a      = aligned && (region == 2'd1) && idx_ok;
    assign is_b      = aligned && (region == 2'd2) && idx_ok;
    assign is_sum    = aligned && (region == 2'd3) && idx_ok;
    assign wr_en     = reg_bus.req && reg_bus.we;
    assign rd_en     = reg_bus.req && !reg_bus.we;
    assign run       = (state_q == S_RUN);
    assign word_sh   = {idx, 5'b00000};

    // Byte-enable mask for the addressed word, placed at its position in the operand.
    logic [31:0]      wmask32;
    logic [WIDTH-1:0] wmask_full, wdata_full;
    assign wmask32    = {{8{reg_bus.be[3]}}, {8{reg_bus.be[2]}},
                         {8{reg_bus.be[1]}}, {8{reg_bus.be[0]}}};
    assign wmask_full = WIDTH'(wmask32) << word_sh;
    assign wdata_full = WIDTH'(reg_bus.wdata) << word_sh;

    logic ctrl_wr;
    assign ctrl_wr = wr_en && is_ctrl && reg_bus.be[0];

    // ---------------- chunk adder ----------------
    logic [31:0]      bit_base;
    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic [CHUNK:0]   csum;
    assign bit_base = 32'(k_q) * 32'(CHUNK);
    assign a_chunk  = CHUNK'(a_q >> bit_base);
    assign b_chunk  = CHUNK'(b_q >> bit_base) ^ {CHUNK{sub_q}};
    assign csum     = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        done_d  = done_q;
        cout_d  = cout_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;

        if (!run) begin
            if (wr_en && is_a) a_d = (a_q & ~wmask_full) | (wdata_full & wmask_full);
            if (wr_en && is_b) b_d = (b_q & ~wmask_full) | (wdata_full & wmask_full);
            if (ctrl_wr) begin
                sub_d = reg_bus.wdata[1];
                if (reg_bus.wdata[0]) begin
                    // START beats CLR_DONE when both are set.
                    state_d = S_RUN;
                    carry_d = reg_bus.wdata[1];
                    k_d     = '0;
                    done_d  = 1'b0;
                end else if (reg_bus.wdata[2]) begin
                    done_d = 1'b0;
                end
            end
        end else begin
            sum_d   = (sum_q & ~(CMASK << bit_base)) | (WIDTH'(csum[CHUNK-1:0]) << bit_base);
            carry_d = csum[CHUNK];
            if (k_q == K_LAST) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                cout_d  = csum[CHUNK];
                k_d     = '0;
            end else begin
                k_d = k_q + KW'(1);
            end
        end
    end

    // ---------------- read data ----------------
    always_comb begin
        rdata_d = 32'h0;
        if (rd_en) begin
            if (is_ctrl)        rdata_d = {28'h0, ie_rd, 1'b0, sub_q, 1'b0};
            else if (is_status) rdata_d = {29'h0, cout_q, done_q, run};
            else if (is_a)      rdata_d = 32'(a_q >> word_sh);
            else if (is_b)      rdata_d = 32'(b_q >> word_sh);
            else if (is_sum)    rdata_d = 32'(sum_q >> word_sh);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            carry_q  <= carry_d;
            sub_q    <= sub_d;
            done_q   <= done_d;
            cout_q   <= cout_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            rvalid_q <= reg_bus.req;
            rdata_q  <= rdata_d;
        end
    end

`ifdef HWORLD_SEQ_ADDER_IRQ_EN
    // IE stays writable while busy so software can mask the pending interrupt.
    logic ie_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        ie_q <= 1'b0;
        else if (ctrl_wr) ie_q <= reg_bus.wdata[3];
    end
    assign ie_rd = ie_q;
    assign irq_o = done_q & ie_q;
`else
    assign ie_rd = 1'b0;
`endif

    assign reg_bus.gnt    = reg_bus.req;
    assign reg_bus.rvalid = rvalid_q;
    assign reg_bus.rdata  = rdata_q;
endmodule

// File: tb/tb_hworld_seq_adder_top.sv
// tb/tb_hworld_seq_adder_top.sv - self-checking bench for hworld_seq_adder_top (WIDTH=64, CHUNK=8)
module tb_hworld_seq_adder_top;
    localparam int WIDTH = 64;
    localparam int CHUNK = 8;
    localparam int NCH   = WIDTH / CHUNK;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hworld_seq_adder_top_if bus ();
`ifdef HWORLD_SEQ_ADDER_IRQ_EN
    logic irq;
`endif

    hworld_seq_adder_top #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .reg_bus (bus)
`ifdef HWORLD_SEQ_ADDER_IRQ_EN
        ,
        .irq_o   (irq)
`endif
    );

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
        logic [31:0] mask;
    } sb_t;
    sb_t sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b, input logic sub);
        logic [63:0] bb;
        bb = sub ? ~b : b;
        return {1'b0, a} + {1'b0, bb} + 65'(sub);
    endfunction

    // One bus transfer: request in one cycle, response sampled in the next.
    task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata);
        @(negedge clk);
        bus.req   = 1'b1;
        bus.we    = we;
        bus.addr  = addr;
        bus.wdata = wdata;
        bus.be    = be;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        bus.we  = 1'b0;
        chk("rvalid", 32'(bus.rvalid), 32'd1);
        rdata = bus.rdata;
    endtask

    task automatic rd_m(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                        input logic [31:0] mask);
        logic [31:0] r;
        sb_t e;
        sb_q.push_back('{tag, exp, mask});
        xfer(1'b0, addr, 32'h0, 4'hF, r);
        e = sb_q.pop_front();
        chk(e.tag, r & e.mask, e.exp & e.mask);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        rd_m(tag, addr, exp, 32'hFFFF_FFFF);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        logic [31:0] r;
        sb_t e;
        sb_q.push_back('{"wr_rsp", 32'h0, 32'hFFFF_FFFF});
        xfer(1'b1, addr, data, be, r);
        e = sb_q.pop_front();
        chk(e.tag, r & e.mask, e.exp & e.mask);
    endtask

    task automatic load_ops(input logic [63:0] a, input logic [63:0] b);
        wr(32'h40, a[31:0], 4'hF);
        wr(32'h44, a[63:32], 4'hF);
        wr(32'h80, b[31:0], 4'hF);
        wr(32'h84, b[63:32], 4'hF);
    endtask

    task automatic wait_idle();
        logic [31:0] r;
        int n;
        n = 0;
        do begin
            xfer(1'b0, 32'h4, 32'h0, 4'hF, r);
            n++;
        end while (r[0] && n < 40);
        n_vec++;
        assert (n < 40) else begin
            n_miss++;
            $error("FAIL busy_timeout: observed %0d polls expected fewer than 40", n);
        end
    endtask

    task automatic check_result(input string tag, input logic [63:0] a, input logic [63:0] b,
                                input logic sub);
        logic [64:0] m;
        m = model(a, b, sub);
        rd({tag, "_sum_lo"}, 32'hC0, m[31:0]);
        rd({tag, "_sum_hi"}, 32'hC4, m[63:32]);
        rd_m({tag, "_status"}, 32'h4, {29'h0, m[64], 2'b10}, 32'h7);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] ta, tb_op;
        logic [64:0] m;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0; bus.be = 4'h0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_rdata", bus.rdata, 32'h0);
        rst = 1'b0;
        rd("rst_status", 32'h4, 32'h0);
        rd("rst_ctrl", 32'h0, 32'h0);
        rd("rst_sum0", 32'hC0, 32'h0);

        // 1: all-ones + 1, exact busy window
        load_ops(64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
        wr(32'h0, 32'h1, 4'hF);
        for (int i = 0; i < NCH; i++) rd_m("t1_busy", 32'h4, 32'h1, 32'h3);
        rd("t1_done", 32'h4, 32'h6);
        check_result("t1", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);

        // 2: subtraction both ways
        load_ops(64'd5, 64'd7);
        wr(32'h0, 32'h3, 4'hF);
        wait_idle();
        check_result("t2a", 64'd5, 64'd7, 1'b1);
        rd("t2_ctrl_sub", 32'h0, 32'h2);
        load_ops(64'd7, 64'd5);
        wr(32'h0, 32'h3, 4'hF);
        wait_idle();
        check_result("t2b", 64'd7, 64'd5, 1'b1);

        // 3: writes while busy are ignored, second START does not restart
        ta = 64'h0123_4567_89AB_CDEF;
        tb_op = 64'h1111_1111_FFFF_FFFF;
        m = model(ta, tb_op, 1'b0);
        load_ops(ta, tb_op);
        wr(32'h0, 32'h1, 4'hF);
        wr(32'h40, 32'h0000_DEAD, 4'hF);
        wr(32'h0, 32'h1, 4'hF);
        for (int i = 0; i < NCH - 2; i++) rd_m("t3_busy", 32'h4, 32'h1, 32'h3);
        rd_m("t3_done", 32'h4, {29'h0, m[64], 2'b10}, 32'h7);
        rd("t3_a0", 32'h40, 32'h89AB_CDEF);
        check_result("t3", ta, tb_op, 1'b0);

        // 4: reset in RUN cycle 3, with a read presented during reset
        load_ops(64'h0F0F_0F0F_0F0F_0F0F, 64'h1234_5678_9ABC_DEF0);
        wr(32'h0, 32'h1, 4'hF);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h4;
        #1;
        chk("t4_rst_rvalid", 32'(bus.rvalid), 32'd0);
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        chk("t4_drop_rvalid", 32'(bus.rvalid), 32'd0);
        chk("t4_drop_rdata", bus.rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rd("t4_status", 32'h4, 32'h0);
        rd("t4_sum0", 32'hC0, 32'h0);
        rd("t4_sum1", 32'hC4, 32'h0);
        rd("t4_a0", 32'h40, 32'h0);
        ta = 64'h8000_0000_0000_0001;
        tb_op = 64'h8000_0000_0000_0001;
        m = model(ta, tb_op, 1'b0);
        load_ops(ta, tb_op);
        wr(32'h0, 32'h1, 4'hF);
        wait_idle();
        check_result("t4_rerun", ta, tb_op, 1'b0);

        // 5: byte enables, unmapped offsets, RO SUM, aliasing, response timing
        wr(32'h40, 32'h0, 4'hF);
        wr(32'h40, 32'hAABB_CCDD, 4'b0001);
        rd("t5_be0", 32'h40, 32'h0000_00DD);
        wr(32'h40, 32'h1122_3344, 4'b0100);
        rd("t5_be2", 32'h40, 32'h0022_00DD);
        rd("t5_alias", 32'h1000_0040, 32'h0022_00DD);
        rd("t5_unmapped", 32'h20, 32'h0);
        @(posedge clk);
        #1;
        chk("t5_rvalid_1cyc", 32'(bus.rvalid), 32'd0);
        wr(32'h88, 32'h5555_5555, 4'hF);
        rd("t5_b2_oob", 32'h88, 32'h0);
        wr(32'hC0, 32'h1234_5678, 4'hF);
        rd("t5_sum_ro", 32'hC0, m[31:0]);
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h20;
        #1;
        chk("t5_gnt_hi", 32'(bus.gnt), 32'd1);
        bus.req = 1'b0;
        #1;
        chk("t5_gnt_lo", 32'(bus.gnt), 32'd0);

        // CTRL semantics: be[0] gating, CLR_DONE
        wr(32'h0, 32'h2, 4'hF);
        wr(32'h0, 32'h0, 4'b1110);
        rd("ctrl_be0_gate", 32'h0, 32'h2);
        rd_m("done_before_clr", 32'h4, 32'h2, 32'h2);
        wr(32'h0, 32'h4, 4'hF);
        rd_m("done_after_clr", 32'h4, 32'h0, 32'h3);

`ifdef HWORLD_SEQ_ADDER_IRQ_EN
        // 6: irq follows DONE & IE
        load_ops(64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
        wr(32'h0, 32'h9, 4'hF);
        for (int i = 0; i < NCH; i++) begin
            chk("t6_irq_low", 32'(irq), 32'd0);
            @(posedge clk);
            #1;
        end
        chk("t6_irq_rise", 32'(irq), 32'd1);
        rd("t6_ctrl_ie", 32'h0, 32'h8);
        wr(32'h0, 32'hC, 4'hF);
        chk("t6_irq_clr", 32'(irq), 32'd0);
`else
        wr(32'h0, 32'h8, 4'hF);
        rd("ie_absent", 32'h0, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
